// File: rtl/fsm_relay_array.sv
// Debounced sensor-to-relay controller, N independent channels, with min-on, cool-down and over-time lockout.
// Latency: relay/fault are registered; relay rises DEB ticks after on_cond first holds; async rst clears at once.
// Backpressure: none (free-running tick clock); enable=0 parks every channel in OFF on the next tick.
//
// Ports:
//   clk_16ms           tick clock, one state step per rising edge
//   rst                asynchronous active-high reset
//   enable             global run enable
//   threshold [W]      hysteresis band shared by all channels
//   sen, sen_ref [N*W] packed per-channel sensor / reference, channel i at [i*W +: W]
//   relay [N]          relay drive (1 only while channel is ON)
//   fault [N]          lockout flag (1 only while channel is LOCKed)
module fsm_relay_array #(
    parameter int N       = 3,
    parameter int W       = 12,
    parameter int DEB     = 4,
    parameter int MIN_ON  = 63,
    parameter int MAX_ON  = 3750,
    parameter int MIN_OFF = 63
) (
    input  logic           clk_16ms,
    input  logic           rst,
    input  logic           enable,
    input  logic [W-1:0]   threshold,
    input  logic [N*W-1:0] sen,
    input  logic [N*W-1:0] sen_ref,
    output logic [N-1:0]   relay,
    output logic [N-1:0]   fault
);

    // Counter must hold the largest terminal count of any state.
    localparam int CMAX_A = (DEB > MAX_ON) ? DEB : MAX_ON;
    localparam int CMAX   = (CMAX_A > MIN_OFF) ? CMAX_A : MIN_OFF;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_ARM  = 3'd1,
        S_ON   = 3'd2,
        S_COOL = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] cnt_inc;
        logic          relay_q, fault_q;
        logic [W-1:0]  sen_i, ref_i;
        logic [W:0]    on_level;
        logic          on_cond, off_cond;

        // Reference plus band is formed one bit wider so a large threshold
        // can never wrap around and fake a trigger.
        always_comb begin
            sen_i    = sen[i*W +: W];
            ref_i    = sen_ref[i*W +: W];
            on_level = {1'b0, ref_i} + {1'b0, threshold};
            on_cond  = ({1'b0, sen_i} > on_level);
            off_cond = (sen_i <= ref_i);
            cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (!enable) begin
                state_d = S_OFF;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    S_OFF: begin
                        cnt_d = '0;
                        if (on_cond) begin
                            state_d = (DEB == 1) ? S_ON : S_ARM;
                            cnt_d   = CW'(1);
                        end
                    end
                    S_ARM: begin
                        if (!on_cond) begin
                            state_d = S_OFF;
                            cnt_d   = '0;
                        end else if (cnt_inc == CW'(DEB)) begin
                            state_d = S_ON;
                            cnt_d   = CW'(1);
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    S_ON: begin
                        // cnt is the number of ticks already spent in ON;
                        // the over-time check wins over a normal release.
                        if (cnt_q >= CW'(MAX_ON)) begin
                            state_d = S_LOCK;
                            cnt_d   = '0;
                        end else if (off_cond && (cnt_q >= CW'(MIN_ON))) begin
                            state_d = S_COOL;
                            cnt_d   = CW'(1);
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    S_COOL: begin
                        if (cnt_q >= CW'(MIN_OFF)) begin
                            state_d = S_OFF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    S_LOCK: begin
                        cnt_d = '0;
                    end
                    default: begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_16ms or posedge rst) begin
            if (rst) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
                relay_q <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                relay_q <= (state_d == S_ON);
                fault_q <= (state_d == S_LOCK);
            end
        end

        assign relay[i] = relay_q;
        assign fault[i] = fault_q;
    end

endmodule

// File: tb/tb_fsm_relay_array.sv
// Bench for fsm_relay_array: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_fsm_relay_array;

    localparam int N       = 3;
    localparam int W       = 12;
    localparam int DEB     = 4;
    localparam int MIN_ON  = 8;
    localparam int MAX_ON  = 20;
    localparam int MIN_OFF = 5;

    logic           clk_16ms;
    logic           rst;
    logic           enable;
    logic [W-1:0]   threshold;
    logic [N*W-1:0] sen;
    logic [N*W-1:0] sen_ref;
    logic [N-1:0]   relay;
    logic [N-1:0]   fault;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: per channel, how long the trigger has been seen,
    // how long the relay has been on, how much cool-down remains, and a lock flag.
    int streak    [N];
    int on_ticks  [N];
    int cool_left [N];
    bit locked    [N];

    fsm_relay_array #(
        .N(N), .W(W), .DEB(DEB), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .MIN_OFF(MIN_OFF)
    ) dut (
        .clk_16ms (clk_16ms),
        .rst      (rst),
        .enable   (enable),
        .threshold(threshold),
        .sen      (sen),
        .sen_ref  (sen_ref),
        .relay    (relay),
        .fault    (fault)
    );

    initial clk_16ms = 1'b0;
    always #5 clk_16ms = ~clk_16ms;

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            streak[c]    = 0;
            on_ticks[c]  = 0;
            cool_left[c] = 0;
            locked[c]    = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < N; c++) begin
            int s, r, t;
            bit trig, rel;
            s    = int'(sen[c*W +: W]);
            r    = int'(sen_ref[c*W +: W]);
            t    = int'(threshold);
            trig = (s > r + t);
            rel  = (s <= r);
            if (!enable) begin
                streak[c] = 0; on_ticks[c] = 0; cool_left[c] = 0; locked[c] = 1'b0;
            end else if (locked[c]) begin
                // stays locked
            end else if (on_ticks[c] > 0) begin
                if (on_ticks[c] >= MAX_ON) begin
                    on_ticks[c] = 0;
                    locked[c]   = 1'b1;
                end else if (rel && on_ticks[c] >= MIN_ON) begin
                    on_ticks[c]  = 0;
                    cool_left[c] = MIN_OFF;
                end else begin
                    on_ticks[c]++;
                end
            end else if (cool_left[c] > 0) begin
                cool_left[c]--;
            end else if (trig) begin
                streak[c]++;
                if (streak[c] >= DEB) begin
                    streak[c]   = 0;
                    on_ticks[c] = 1;
                end
            end else begin
                streak[c] = 0;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_relay();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = (on_ticks[c] > 0);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_fault();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = locked[c];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_16ms);
            model_step();
            #1;
            chk({tag, "_relay"}, relay, exp_relay());
            chk({tag, "_fault"}, fault, exp_fault());
        end
    endtask

    task automatic set_ch(input int c, input int s, input int r);
        sen[c*W +: W]     = W'(s);
        sen_ref[c*W +: W] = W'(r);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        threshold = 12'd50;
        sen       = '0;
        sen_ref   = '0;
        for (int c = 0; c < N; c++) set_ch(c, 800, 900);
        model_reset();
        #12;
        chk("reset_relay", relay, '0);
        chk("reset_fault", fault, '0);
        rst = 1'b0;

        // Debounce: three trigger ticks then a gap must not energise.
        set_ch(0, 1000, 900);
        tick(3, "deb_a");
        chk_bit("deb_short_relay0", relay[0], 1'b0);
        set_ch(0, 900, 900);
        tick(1, "deb_gap");
        set_ch(0, 1000, 900);
        tick(3, "deb_b");
        chk_bit("deb_3rd_relay0", relay[0], 1'b0);
        tick(1, "deb_c");
        chk_bit("deb_4th_relay0", relay[0], 1'b1);

        // Min-on then cool-down: release from ON tick 2, drop only after tick 8.
        tick(1, "mon_a");
        set_ch(0, 800, 900);
        tick(6, "mon_b");
        chk_bit("minon_hold_relay0", relay[0], 1'b1);
        tick(1, "mon_c");
        chk_bit("minon_drop_relay0", relay[0], 1'b0);
        set_ch(0, 1000, 900);
        tick(5, "cool_a");
        chk_bit("cool_ignore_relay0", relay[0], 1'b0);
        tick(3, "cool_b");
        chk_bit("cool_rearm_relay0", relay[0], 1'b0);
        tick(1, "cool_c");
        chk_bit("cool_reon_relay0", relay[0], 1'b1);
        set_ch(0, 800, 900);
        enable = 1'b0;
        tick(1, "en_clr");
        chk("en_clr_relay", relay, '0);
        enable = 1'b1;

        // Lockout on channel 1.
        set_ch(1, 1000, 900);
        tick(4, "lk_a");
        chk_bit("lock_on_relay1", relay[1], 1'b1);
        tick(19, "lk_b");
        chk_bit("lock_last_relay1", relay[1], 1'b1);
        tick(1, "lk_c");
        chk_bit("lock_relay1", relay[1], 1'b0);
        chk_bit("lock_fault1", fault[1], 1'b1);
        set_ch(1, 800, 900);
        tick(10, "lk_hold");
        chk_bit("lock_persist_fault1", fault[1], 1'b1);
        enable = 1'b0;
        tick(1, "lk_en");
        chk_bit("lock_clear_fault1", fault[1], 1'b0);
        enable = 1'b1;

        // Arithmetic boundaries on channel 2.
        threshold = 12'd4095;
        set_ch(2, 4095, 4095);
        tick(8, "ar_max");
        chk_bit("arith_max_relay2", relay[2], 1'b0);
        threshold = 12'd50;
        set_ch(2, 950, 900);
        tick(6, "ar_eq");
        chk_bit("arith_eq_relay2", relay[2], 1'b0);
        set_ch(2, 951, 900);
        tick(4, "ar_gt");
        chk_bit("arith_gt_relay2", relay[2], 1'b1);
        set_ch(2, 800, 900);
        enable = 1'b0;
        tick(1, "ar_clr");
        enable = 1'b1;

        // Async reset with ch0 ON and ch2 LOCK.
        set_ch(2, 1000, 900);
        tick(10, "ar_l2");
        set_ch(0, 1000, 900);
        tick(15, "ar_on0");
        chk_bit("arst_pre_relay0", relay[0], 1'b1);
        chk_bit("arst_pre_fault2", fault[2], 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_relay", relay, '0);
        chk("arst_fault", fault, '0);
        #1;
        rst = 1'b0;
        tick(1, "arst_post");
        chk_bit("arst_restart_relay0", relay[0], 1'b0);
        tick(3, "arst_rearm");
        chk_bit("arst_rearm_relay0", relay[0], 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    int r, s;
                    r = int'($urandom_range(0, 4095));
                    s = r + int'($urandom_range(0, 300)) - 100;
                    if (s < 0) s = 0;
                    if (s > 4095) s = 4095;
                    set_ch(c, s, r);
                end
            end
            if ($urandom_range(0, 19) == 0) threshold = W'($urandom_range(0, 120));
            enable = ($urandom_range(0, 59) != 0);
            tick(1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
